hiscore_ioctl_master: RTL and testbench
=======================================

# hiscore_ioctl_master

Drives the HPS-side ioctl transfer protocol into the hiscore block: streams a local byte buffer to the core as an indexed download (config or dump), or performs an upload, sampling `ioctl_din` per address into a capture buffer. Used in standalone and simulation builds with no HPS, and as the bench driver for hiscore. Sits beside the core; its `ioctl_*` outputs connect directly to the hiscore `ioctl_*` inputs.

## Interface
- `ADDRESSWIDTH`, 8: width of source/capture buffer addresses; max transfer 2^ADDRESSWIDTH bytes.
- `WR_GAP`, 4: idle cycles after each `ioctl_wr` strobe (min 1).
- `UL_SETTLE`, 4: cycles each upload address is held before `ioctl_din` is sampled (min 1).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start_download`  in  1  request download; sampled in IDLE only.
- `start_upload`  in  1  request upload; sampled in IDLE only.
- `xfer_index`  in  8  value presented on `ioctl_index`; latched at start.
- `xfer_length`  in  ADDRESSWIDTH+1  byte count N, 0..2^ADDRESSWIDTH; latched at start.
- `src_addr`  out  ADDRESSWIDTH  source buffer read address.
- `src_data`  in  8  source buffer data, valid 1 cycle after `src_addr`.
- `cap_addr`  out  ADDRESSWIDTH  capture buffer write address.
- `cap_data`  out  8  capture buffer write data.
- `cap_we`  out  1  capture write strobe, one cycle per byte.
- `ioctl_download`  out  1  download active.
- `ioctl_upload`  out  1  upload active.
- `ioctl_wr`  out  1  download byte strobe.
- `ioctl_addr`  out  25  byte address within the transfer.
- `ioctl_dout`  out  8  download data.
- `ioctl_din`  in  8  upload data returned by the core.
- `ioctl_index`  out  8  transfer index.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at transfer end.

## Operation
- Reset value of every output is 0. Asserting `reset` mid-transfer drops `ioctl_download` and `ioctl_upload` immediately. No done pulse is generated. The receiver then sees a falling edge, which is accepted behaviour.
- States: IDLE, DL_FETCH, DL_WR, DL_GAP, UL_HOLD, UL_CAP.
- IDLE: `start_download` has priority over `start_upload` when both are high. Latch index and N, and set `ioctl_index`. With N=0, pulse `done` next cycle, produce no ioctl activity, and stay IDLE.
- Download start: set `ioctl_download`=1, `ioctl_addr`=0, `src_addr`=0, `busy`=1, then go to DL_FETCH.
- DL_FETCH (1 cycle) → DL_WR.
- DL_WR: `ioctl_dout`=`src_data`, `ioctl_wr`=1 for exactly one cycle → DL_GAP.
- DL_GAP: runs `WR_GAP` cycles with `ioctl_wr`=0.
  - If `ioctl_addr`=N-1: drop `ioctl_download`, clear `busy`, pulse `done`, return to IDLE.
  - Otherwise: increment `ioctl_addr` and `src_addr`, go to DL_FETCH.
- `ioctl_addr` is stable throughout FETCH/WR/GAP of each byte.
- Upload start: set `ioctl_upload`=1, `ioctl_addr`=0, `busy`=1, then go to UL_HOLD.
- UL_HOLD: counts `UL_SETTLE` cycles → UL_CAP.
- UL_CAP: register `cap_data`=`ioctl_din`, `cap_addr`=`ioctl_addr[ADDRESSWIDTH-1:0]`, and `cap_we`=1 during the following cycle.
  - If last byte: drop `ioctl_upload`, pulse `done`, go to IDLE.
  - Otherwise: increment address, go to UL_HOLD.
- `ioctl_index` holds its value after a transfer until the next start. The receiver samples the index after the download falling edge.
- Starts while `busy` are ignored; there is no queueing.
- Arithmetic: the address counter is ADDRESSWIDTH+1 bits wide, compared against N-1. `ioctl_addr` is zero-extended to 25 bits. N=2^ADDRESSWIDTH ends at address 2^ADDRESSWIDTH-1 with no wrap.

## Timing
- Start sampled at edge E0. `ioctl_download`/`ioctl_upload` rise at E1 with `ioctl_addr`=0.
- Download:
  - Per-byte period is `WR_GAP`+2 cycles.
  - `ioctl_wr` for byte k is high during cycle E1+1+k·(`WR_GAP`+2).
  - `ioctl_download` falls and `done` pulses at E1+N·(`WR_GAP`+2).
- Upload:
  - Per-byte period is `UL_SETTLE`+1 cycles.
  - `done` and the fall of `ioctl_upload` occur at E1+N·(`UL_SETTLE`+1).
  - `cap_we` for the final byte coincides with the `done` cycle.
- `busy` is high from E1 through the cycle before `done`. `done` and `busy` are never high together.

## Test plan
- Download N=3, index 3, src={0x00,0x43,0x0B}, `WR_GAP`=4 → three `ioctl_wr` pulses 6 cycles apart with addr 0,1,2 and matching dout; `ioctl_download` high 18 cycles; `done` at E1+18; index stays 3 afterwards.
- Upload N=4 with `ioctl_din`=0xA0+`ioctl_addr` (combinational model) → capture writes 0xA0..0xA3 to addresses 0..3; `done` at E1+20.
- N=0 download → `done` at E1, no `ioctl_download`/`ioctl_wr` activity, `busy` stays 0.
- `start_download` and `start_upload` same cycle, N=2 → download only; `start_upload` during busy ignored; `ioctl_upload` never rises.
- `reset` asserted mid-download at byte 1 → all outputs 0 asynchronously, no `done`; a fresh start after release begins at addr 0.
- N=256, ADDRESSWIDTH=8 → 256 strobes; last `ioctl_addr`=0x0FF; `src_addr` covers 0..255; no wrap to 0 before `done`.

Source files
------------

// File: rtl/hiscore_ioctl_master_if.sv
// Ioctl transfer bus between the standalone master and the hiscore core.
// The master drives everything except ioctl_din, which the core returns during uploads.
interface hiscore_ioctl_master_if;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic [7:0]  ioctl_index;

    modport master (
        output ioctl_download, ioctl_upload, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  ioctl_din
    );

    modport slave (
        input  ioctl_download, ioctl_upload, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output ioctl_din
    );
endinterface

// File: rtl/hiscore_ioctl_master.sv
// HPS-less ioctl driver for hiscore: streams a source buffer as a download, or
// walks the upload address space and writes ioctl_din into a capture buffer.
//
// state      | meaning
// IDLE       | waiting for start_download / start_upload
// DL_FETCH   | src_addr presented, source RAM read in flight
// DL_WR      | ioctl_wr strobe with ioctl_dout = src_data
// DL_GAP     | WR_GAP idle cycles before next byte or end
// UL_HOLD    | UL_SETTLE cycles holding the upload address
// UL_CAP     | sample ioctl_din, then next address or end
module hiscore_ioctl_master #(
    parameter int ADDRESSWIDTH = 8,
    parameter int WR_GAP       = 4,
    parameter int UL_SETTLE    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_download,
    input  logic                    start_upload,
    input  logic [7:0]              xfer_index,
    input  logic [ADDRESSWIDTH:0]   xfer_length,
    output logic [ADDRESSWIDTH-1:0] src_addr,
    input  logic [7:0]              src_data,
    output logic [ADDRESSWIDTH-1:0] cap_addr,
    output logic [7:0]              cap_data,
    output logic                    cap_we,
    output logic                    busy,
    output logic                    done,
    hiscore_ioctl_master_if.master  ioctl
);

    localparam int TMAX = (WR_GAP > UL_SETTLE) ? WR_GAP : UL_SETTLE;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
    localparam logic [TW-1:0]           T_GAP    = TW'(WR_GAP - 1);
    localparam logic [TW-1:0]           T_SETTLE = TW'(UL_SETTLE - 1);
    localparam logic [TW-1:0]           T_ONE    = TW'(1);
    localparam logic [ADDRESSWIDTH:0]   A_ONE    = (ADDRESSWIDTH+1)'(1);
    localparam logic [ADDRESSWIDTH-1:0] S_ONE    = ADDRESSWIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_DL_FETCH, S_DL_WR, S_DL_GAP, S_UL_HOLD, S_UL_CAP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDRESSWIDTH:0]   addr_q, addr_d;
    logic [ADDRESSWIDTH:0]   len_q, len_d;
    logic [7:0]              index_q, index_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    dl_q, dl_d;
    logic                    ul_q, ul_d;
    logic                    wr_q, wr_d;
    logic [7:0]              dout_q, dout_d;
    logic [ADDRESSWIDTH-1:0] src_q, src_d;
    logic [ADDRESSWIDTH-1:0] cap_addr_q, cap_addr_d;
    logic [7:0]              cap_data_q, cap_data_d;
    logic                    cap_we_q, cap_we_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    last;

    // Counter is one bit wider than the buffer address so N = 2^ADDRESSWIDTH never wraps.
    assign last = (addr_q == (len_q - A_ONE));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        index_d    = index_q;
        timer_d    = timer_q;
        dl_d       = dl_q;
        ul_d       = ul_q;
        wr_d       = 1'b0;
        dout_d     = dout_q;
        src_d      = src_q;
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        cap_we_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_download || start_upload) begin
                    index_d = xfer_index;
                    len_d   = xfer_length;
                    if (xfer_length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d = '0;
                        busy_d = 1'b1;
                        if (start_download) begin
                            dl_d    = 1'b1;
                            src_d   = '0;
                            state_d = S_DL_FETCH;
                        end else begin
                            ul_d    = 1'b1;
                            timer_d = T_SETTLE;
                            state_d = S_UL_HOLD;
                        end
                    end
                end
            end
            S_DL_FETCH: begin
                wr_d    = 1'b1;
                state_d = S_DL_WR;
            end
            S_DL_WR: begin
                dout_d  = src_data;
                timer_d = T_GAP;
                state_d = S_DL_GAP;
            end
            S_DL_GAP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - T_ONE;
                end else if (last) begin
                    dl_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + A_ONE;
                    src_d   = src_q + S_ONE;
                    state_d = S_DL_FETCH;
                end
            end
            S_UL_HOLD: begin
                if (timer_q != '0) timer_d = timer_q - T_ONE;
                else               state_d = S_UL_CAP;
            end
            S_UL_CAP: begin
                cap_data_d = ioctl.ioctl_din;
                cap_addr_d = addr_q[ADDRESSWIDTH-1:0];
                cap_we_d   = 1'b1;
                if (last) begin
                    ul_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + A_ONE;
                    timer_d = T_SETTLE;
                    state_d = S_UL_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            index_q    <= '0;
            timer_q    <= '0;
            dl_q       <= 1'b0;
            ul_q       <= 1'b0;
            wr_q       <= 1'b0;
            dout_q     <= '0;
            src_q      <= '0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            cap_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            index_q    <= index_d;
            timer_q    <= timer_d;
            dl_q       <= dl_d;
            ul_q       <= ul_d;
            wr_q       <= wr_d;
            dout_q     <= dout_d;
            src_q      <= src_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            cap_we_q   <= cap_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Source RAM data only arrives in the strobe cycle, so pass it through then and hold it after.
    assign ioctl.ioctl_dout     = wr_q ? src_data : dout_q;
    assign ioctl.ioctl_download = dl_q;
    assign ioctl.ioctl_upload   = ul_q;
    assign ioctl.ioctl_wr       = wr_q;
    assign ioctl.ioctl_addr     = 25'(addr_q);
    assign ioctl.ioctl_index    = index_q;
    assign src_addr             = src_q;
    assign cap_addr             = cap_addr_q;
    assign cap_data             = cap_data_q;
    assign cap_we               = cap_we_q;
    assign busy                 = busy_q;
    assign done                 = done_q;

endmodule

// File: tb/tb_hiscore_ioctl_master.sv
// Randomized bench for hiscore_ioctl_master: expected strobe/capture timing and data
// are computed from the transfer length, index and buffer contents.
module tb_hiscore_ioctl_master;
    localparam int AW = 8;
    localparam int G  = 4;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_download = 1'b0;
    logic          start_upload = 1'b0;
    logic [7:0]    xfer_index = '0;
    logic [AW:0]   xfer_length = '0;
    logic [AW-1:0] src_addr, cap_addr;
    logic [7:0]    src_data, cap_data;
    logic          cap_we, busy, done;

    hiscore_ioctl_master_if ioctl_if();

    logic [7:0] mem [256];
    logic [7:0] din_tab [256];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t wr_log[$];
    ev_t cap_log[$];
    int  done_log[$];
    int  dl_cycles, ul_cycles, busy_cycles;

    hiscore_ioctl_master #(.ADDRESSWIDTH(AW), .WR_GAP(G), .UL_SETTLE(S)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_download (start_download),
        .start_upload   (start_upload),
        .xfer_index     (xfer_index),
        .xfer_length    (xfer_length),
        .src_addr       (src_addr),
        .src_data       (src_data),
        .cap_addr       (cap_addr),
        .cap_data       (cap_data),
        .cap_we         (cap_we),
        .busy           (busy),
        .done           (done),
        .ioctl          (ioctl_if)
    );

    always #5 clk = ~clk;

    // Synchronous source RAM: data valid one cycle after src_addr.
    always @(posedge clk) src_data <= mem[src_addr];

    // Core upload model: combinational lookup by current address.
    assign ioctl_if.ioctl_din = din_tab[ioctl_if.ioctl_addr[AW-1:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (ioctl_if.ioctl_wr)
                wr_log.push_back('{cyc, 32'(ioctl_if.ioctl_addr), 32'(ioctl_if.ioctl_dout)});
            if (cap_we)
                cap_log.push_back('{cyc, 32'(cap_addr), 32'(cap_data)});
            if (done) begin
                done_log.push_back(cyc);
                chk("done_not_busy", 32'(busy), 32'd0);
            end
            if (ioctl_if.ioctl_download) dl_cycles++;
            if (ioctl_if.ioctl_upload)   ul_cycles++;
            if (busy)                    busy_cycles++;
        end
    end

    task automatic clear_log();
        wr_log.delete();
        cap_log.delete();
        done_log.delete();
        dl_cycles   = 0;
        ul_cycles   = 0;
        busy_cycles = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            din_tab[i] = 8'($urandom);
        end
    endtask

    task automatic run_xfer(input bit dl, input bit ul, input logic [7:0] idx, input int n,
                            input bit poke);
        int c0, dur, nwr, ncap;
        clear_log();
        dur  = (n == 0) ? 0 : (dl ? n * (G + 2) : n * (S + 1));
        nwr  = (n > 0 && dl)  ? n : 0;
        ncap = (n > 0 && !dl) ? n : 0;
        @(negedge clk); #1;
        c0 = cyc + 1;
        start_download = dl;
        start_upload   = ul;
        xfer_index     = idx;
        xfer_length    = (AW+1)'(n);
        @(posedge clk); #1;
        start_download = 1'b0;
        start_upload   = 1'b0;
        while (done_log.size() == 0 && cyc < c0 + dur + 40) begin
            @(negedge clk); #1;
            if (poke && n > 0 && cyc == c0 + 1) begin
                start_upload   = 1'b1;
                start_download = 1'($urandom_range(0, 1));
            end
            if (cyc == c0 + 3) begin
                start_upload   = 1'b0;
                start_download = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        #1;
        chk("done_count", done_log.size(), 1);
        if (done_log.size() > 0) chk("done_cycle", done_log[0], c0 + dur);
        chk("wr_count", wr_log.size(), nwr);
        chk("cap_count", cap_log.size(), ncap);
        for (int k = 0; k < nwr && k < wr_log.size(); k++) begin
            chk("wr_cycle", wr_log[k].c, c0 + 1 + k * (G + 2));
            chk("wr_addr", wr_log[k].a, k);
            chk("wr_dout", wr_log[k].d, 32'(mem[k]));
        end
        for (int k = 0; k < ncap && k < cap_log.size(); k++) begin
            chk("cap_cycle", cap_log[k].c, c0 + (k + 1) * (S + 1));
            chk("cap_addr", cap_log[k].a, k);
            chk("cap_data", cap_log[k].d, 32'(din_tab[k]));
        end
        chk("dl_cycles", dl_cycles, (n > 0 && dl) ? dur : 0);
        chk("ul_cycles", ul_cycles, (n > 0 && !dl) ? dur : 0);
        chk("busy_cycles", busy_cycles, dur);
        chk("index_hold", 32'(ioctl_if.ioctl_index), 32'(idx));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        bit dl;
        logic [7:0] idx;

        fill_random();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_download", 32'(ioctl_if.ioctl_download), 0);
        chk("rst_upload", 32'(ioctl_if.ioctl_upload), 0);
        chk("rst_wr", 32'(ioctl_if.ioctl_wr), 0);
        chk("rst_addr", 32'(ioctl_if.ioctl_addr), 0);
        chk("rst_dout", 32'(ioctl_if.ioctl_dout), 0);
        chk("rst_index", 32'(ioctl_if.ioctl_index), 0);
        chk("rst_busy_done", {30'd0, busy, done}, 0);
        chk("rst_cap", {cap_we, 7'd0, cap_addr, cap_data, src_addr}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Known-content download, N=3, index 3.
        mem[0] = 8'h00; mem[1] = 8'h43; mem[2] = 8'h0B;
        run_xfer(1'b1, 1'b0, 8'd3, 3, 1'b0);

        // Upload N=4 with din = 0xA0 + addr.
        for (int i = 0; i < 256; i++) din_tab[i] = 8'(8'hA0 + i);
        run_xfer(1'b0, 1'b1, 8'h5C, 4, 1'b0);

        // Zero-length download.
        run_xfer(1'b1, 1'b0, 8'h21, 0, 1'b0);

        // Simultaneous starts plus a start_upload while busy.
        fill_random();
        run_xfer(1'b1, 1'b1, 8'h77, 2, 1'b1);

        // Reset in the middle of byte 1.
        clear_log();
        @(negedge clk); #1;
        start_download = 1'b1;
        xfer_index     = 8'h9A;
        xfer_length    = (AW+1)'(3);
        @(posedge clk); #1;
        start_download = 1'b0;
        t = 0;
        while (ioctl_if.ioctl_addr != 25'd1 && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        chk("rst_reach_byte1", 32'(t < 100), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_download", 32'(ioctl_if.ioctl_download), 0);
        chk("midrst_addr", 32'(ioctl_if.ioctl_addr), 0);
        chk("midrst_src_addr", 32'(src_addr), 0);
        chk("midrst_index", 32'(ioctl_if.ioctl_index), 0);
        chk("midrst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_no_done", done_log.size(), 0);
        run_xfer(1'b1, 1'b0, 8'h9B, 3, 1'b0);

        // Full-size transfer.
        fill_random();
        run_xfer(1'b1, 1'b0, 8'hFF, 256, 1'b0);

        for (int it = 0; it < 12; it++) begin
            fill_random();
            dl  = 1'($urandom_range(0, 1));
            n   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
            idx = 8'($urandom);
            run_xfer(dl, dl ? 1'($urandom_range(0, 1)) : 1'b1, idx, n,
                     1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
